// File: rtl/fifo_arb_pkg.sv
// Shared types and default constants for the FIFO push arbiter.
// This package also holds the grant FSM state encoding.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MAX_BURST = 4;
  localparam int BURST_W       = 4;

endpackage

// File: rtl/fifo_push_arbiter_rr_pick.sv
// Round-robin picker: finds the first set request bit at or after the pointer.
// The search runs upward through the request vector and wraps past the top.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PW-1:0]      i_ptr,
  output logic               o_valid,
  output logic [PW-1:0]      o_idx
);

  localparam logic [PW:0] NUM_W = (PW+1)'(NUM_REQ);

  logic [PW:0]   w_sum;
  logic [PW-1:0] w_cand;

  // Earliest hit in search order wins; the extra sum bit absorbs the wrap.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_sum   = '0;
    w_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, i_ptr} + (PW+1)'(k);
      if (w_sum >= NUM_W) begin
        w_sum = w_sum - NUM_W;
      end
      w_cand = w_sum[PW-1:0];
      if (!o_valid && i_req[w_cand]) begin
        o_valid = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Multiplexes NUM_REQ write requesters onto one FIFO push port.
// Grants are round-robin, and each grant is limited to MAX_BURST words.
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                       sclk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  wdata,
  input  logic                       full,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       push,
  output logic [DATA_W-1:0]          d_in,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       busy
);

  localparam int PW = $clog2(NUM_REQ);

  arb_state_e         r_state, w_stateNext;
  logic [NUM_REQ-1:0] r_gnt, w_gntNext;
  logic [PW-1:0]      r_owner, w_ownerNext;
  logic [PW-1:0]      r_rrPtr, w_ptrNext;
  logic [BURST_W-1:0] r_burst, w_burstNext;

  logic [NUM_REQ-1:0] w_pickReq;
  logic               w_pickValid;
  logic [PW-1:0]      w_pickIdx;
  logic [PW-1:0]      w_pickIdxInc;
  logic               w_accept;
  logic               w_lastWord;
  logic               w_release;
  logic [DATA_W-1:0]  w_slot [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
    assign w_slot[g] = wdata[g*DATA_W +: DATA_W];
  end

  assign w_accept   = (r_state == BUSY) & req[r_owner] & r_gnt[r_owner] & ~full;
  assign w_lastWord = (r_burst == BURST_W'(MAX_BURST - 1));
  assign w_release  = (r_state == BUSY) & ((w_accept & w_lastWord) | ~req[r_owner]);

  // While busy the current owner is masked, so a release rotates to someone else.
  assign w_pickReq    = (r_state == BUSY) ? (req & ~r_gnt) : req;
  assign w_pickIdxInc = (w_pickIdx == PW'(NUM_REQ - 1)) ? '0 : w_pickIdx + 1'b1;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_rr_pick (
    .i_req   (w_pickReq),
    .i_ptr   (r_rrPtr),
    .o_valid (w_pickValid),
    .o_idx   (w_pickIdx)
  );

  assign push  = w_accept;
  assign d_in  = w_slot[r_owner];
  assign gnt   = r_gnt;
  assign owner = r_owner;
  assign busy  = (r_state == BUSY);

  always_comb begin
    w_stateNext = r_state;
    w_gntNext   = r_gnt;
    w_ownerNext = r_owner;
    w_ptrNext   = r_rrPtr;
    w_burstNext = r_burst;
    case (r_state)
      IDLE: begin
        if (w_pickValid) begin
          w_stateNext = BUSY;
          w_gntNext   = NUM_REQ'(1) << w_pickIdx;
          w_ownerNext = w_pickIdx;
          w_ptrNext   = w_pickIdxInc;
          w_burstNext = '0;
        end
      end
      BUSY: begin
        if (w_accept) begin
          w_burstNext = r_burst + 1'b1;
        end
        if (w_release) begin
          if (w_pickValid) begin
            w_gntNext   = NUM_REQ'(1) << w_pickIdx;
            w_ownerNext = w_pickIdx;
            w_ptrNext   = w_pickIdxInc;
            w_burstNext = '0;
          end else if (req[r_owner]) begin
            // Sole requester that hit the burst limit keeps going with a fresh burst.
            w_burstNext = '0;
          end else begin
            w_stateNext = IDLE;
            w_gntNext   = '0;
            w_ownerNext = '0;
            w_burstNext = '0;
          end
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_gntNext   = '0;
        w_ownerNext = '0;
        w_burstNext = '0;
      end
    endcase
  end

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_owner <= '0;
      r_rrPtr <= '0;
      r_burst <= '0;
    end else begin
      r_state <= w_stateNext;
      r_gnt   <= w_gntNext;
      r_owner <= w_ownerNext;
      r_rrPtr <= w_ptrNext;
      r_burst <= w_burstNext;
    end
  end

endmodule

// File: doc/fifo_push_arbiter.md
FIFO_PUSH_ARBITER -- requirements
Module: fifo_push_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of write requesters (2..8).
REQ-002 SHALL have parameter DATA_W, default 8, FIFO data width.
REQ-003 SHALL have parameter MAX_BURST, default 4, max consecutive words per grant (1..16).
REQ-004 SHALL have port sclk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req  input  NUM_REQ  per-requester write request; one bit per requester.
REQ-007 SHALL have port wdata  input  NUM_REQ*DATA_W  packed requester data; slice i belongs to requester i.
REQ-008 SHALL have port full  input  1  FIFO full flag.
REQ-009 SHALL have port gnt  output  NUM_REQ  registered one-hot grant, or zero.
REQ-010 SHALL have port push  output  1  FIFO write strobe.
REQ-011 SHALL have port d_in  output  DATA_W  FIFO write data.
REQ-012 SHALL have port owner  output  clog2(NUM_REQ)  index of current grantee; 0 when idle.
REQ-013 SHALL have port busy  output  1  high while in state BUSY.

Function
REQ-014 SHALL implement a two-state FSM: IDLE (gnt=0), BUSY (exactly one gnt bit set).
REQ-015 Accept SHALL be defined as req[owner] & gnt[owner] & !full in a cycle.
REQ-016 push SHALL equal accept combinationally; d_in SHALL equal wdata slice owner, combinationally; d_in undefined-safe (still the mux) when push=0.
REQ-017 IDLE->BUSY SHALL occur on the edge after any req bit is high; the grantee is the first set req bit at or after rr_ptr, searching upward with wrap.
REQ-018 rr_ptr SHALL be set to (grantee+1) mod NUM_REQ whenever a grant is issued.
REQ-019 A 4-bit burst counter SHALL clear on each new grant and increment on each accept.
REQ-020 Release SHALL occur when (accept and burst count = MAX_BURST-1) or req[owner]=0.
REQ-021 On release with another req bit high (excluding the releasing owner), the FSM SHALL stay BUSY and grant the next requester on the following edge with no idle cycle.
REQ-022 On release with no other request, the FSM SHALL go to IDLE on the next edge.
REQ-023 A requester that releases at MAX_BURST and still requests SHALL be re-granted only after every other pending requester has been served, or immediately when it is the only requester.
REQ-024 While full=1 the grant SHALL be held, push=0, burst counter frozen; no rotation due to full.
REQ-025 req[owner] dropping SHALL cause at most one cycle with gnt high and no push.
REQ-026 req bits of non-granted requesters SHALL have no effect on push or d_in.
REQ-027 gnt SHALL never have more than one bit set; push SHALL never assert when gnt=0.

Reset
REQ-028 On rst low: state=IDLE, gnt=0, owner=0, busy=0, rr_ptr=0, burst counter=0; push=0 follows.
REQ-029 Reset asserted mid-burst SHALL drop gnt and push immediately (asynchronous); no word is pushed in that cycle.
REQ-030 After rst deasserts, the first grant SHALL follow REQ-017 with rr_ptr=0.

Structure
REQ-031 A shared package fifo_arb_pkg SHALL hold the FSM state enum (IDLE, BUSY) and default parameter constants.
REQ-032 One sub-module, rr_pick, SHALL compute the next grantee from a request vector and rr_ptr, combinationally.
REQ-033 The block SHALL connect to the FIFO through the team's FIFO interface signals push, d_in, full.

Verification
REQ-034 Single requester: req=4'b0100, full=0, held 6 cycles -> gnt=4'b0100 from cycle 1, push every cycle, owner=2.
REQ-035 All requesting, MAX_BURST=4: req=4'b1111 -> grants 0,1,2,3,0 in order, 4 pushes each, no gap cycles.
REQ-036 Full stall: requester 1 granted, full=1 for 3 cycles after 2 accepts -> gnt held, push=0, then 2 more pushes, then rotate.
REQ-037 Early drop: requester 3 drops req after 1 accept while req[0]=1 -> gnt moves to 4'b0001 on next edge.
REQ-038 Reset mid-burst: rst low during burst word 2 -> gnt=0, push=0 same cycle; after release req=4'b0010 grants requester 1.
REQ-039 Bench SHALL check one-hot gnt and d_in==wdata[owner] on every push, and total pushed words per requester.
